// File: rtl/parity_pkg.sv
// Shared definitions for the bit-serial parity frame checker.
package parity_pkg;

    // Checker FSM states.
    typedef enum logic [1:0] {
        S_DATA   = 2'd0,
        S_PARITY = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    // Failed-frame counter width and its saturation value.
    localparam int               ERR_W   = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = 8'd255;

endpackage : parity_pkg

// File: rtl/parity_frame_checker_xor_gate.sv
// Two-input XOR primitive used to fold each serial bit into the running parity.
module xor_gate (
    input  logic a,
    input  logic b,
    output logic y
);

    // Pure combinational XOR.
    assign y = a ^ b;

endmodule : xor_gate

// File: rtl/parity_frame_checker.sv
// Bit-serial parity checker: folds FRAME_LEN data bits into a running XOR,
// compares against a received parity bit and holds the verdict on an
// output valid/ready handshake.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_DATA   | accepting data bits, acc/cnt advance on each transfer
//   S_PARITY | waiting for the frame's parity bit, verdict latched on it
//   S_HOLD   | verdict presented, input stalled until consumer takes it
module parity_frame_checker
    import parity_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter bit ODD       = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic             out_error,
    output logic [ERR_W-1:0] err_count
);

    localparam int               CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME_LEN - 1);

    state_t           state;
    logic             acc;
    logic             acc_next;
    logic [CNT_W-1:0] cnt;
    logic             in_xfer;
    logic             out_xfer;

    xor_gate u_xor (
        .a (acc),
        .b (in_bit),
        .y (acc_next)
    );

    // Ready depends on state alone, so there is no path from out_ready.
    assign in_ready = (state != S_HOLD);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Frame sequencing, parity accumulation and registered verdict outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_DATA;
            acc        <= 1'b0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_parity <= 1'b0;
            out_error  <= 1'b0;
            err_count  <= '0;
        end else begin
            case (state)
                S_DATA: begin
                    if (in_xfer) begin
                        acc <= acc_next;
                        // cnt parks at LAST rather than wrapping when
                        // FRAME_LEN is a power of two.
                        if (cnt == LAST) begin
                            state <= S_PARITY;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (in_xfer) begin
                        out_parity <= acc ^ ODD;
                        out_error  <= acc_next ^ ODD;
                        out_valid  <= 1'b1;
                        state      <= S_HOLD;
                        if ((acc_next ^ ODD) && (err_count != ERR_MAX)) begin
                            err_count <= err_count + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_xfer) begin
                        out_valid <= 1'b0;
                        acc       <= 1'b0;
                        cnt       <= '0;
                        state     <= S_DATA;
                    end
                end
                default: begin
                    state <= S_DATA;
                end
            endcase
        end
    end

endmodule : parity_frame_checker

// File: tb/tb_parity_frame_checker.sv
// Self-checking bench: an even-parity and an odd-parity instance share one
// stimulus stream; expected verdicts come from bit counting on the frame.
module tb_parity_frame_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready0, out_valid0, out_parity0, out_error0;
    logic [7:0] err_count0;
    logic       in_ready1, out_valid1, out_parity1, out_error1;
    logic [7:0] err_count1;

    int checks = 0;
    int errors = 0;
    int ec0 = 0;
    int ec1 = 0;

    always #5 clk = ~clk;

    parity_frame_checker #(.FRAME_LEN(8), .ODD(1'b0)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready0),
        .in_bit     (in_bit),
        .out_valid  (out_valid0),
        .out_ready  (out_ready),
        .out_parity (out_parity0),
        .out_error  (out_error0),
        .err_count  (err_count0)
    );

    parity_frame_checker #(.FRAME_LEN(8), .ODD(1'b1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready1),
        .in_bit     (in_bit),
        .out_valid  (out_valid1),
        .out_ready  (out_ready),
        .out_parity (out_parity1),
        .out_error  (out_error1),
        .err_count  (err_count1)
    );

    typedef struct {
        logic [7:0] data;     // data[0] is sent first
        logic       par;
        int         gap_at;
        int         gap_len;
        int         hold;
        logic       exp_p0;   // expected out_parity of the even instance
        logic       exp_e0;   // expected out_error of the even instance
    } vec_t;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " in_ready0"}, in_ready0, 1);
        chk({tag, " in_ready1"}, in_ready1, 1);
        chk({tag, " out_valid0"}, out_valid0, 0);
        chk({tag, " out_parity0"}, out_parity0, 0);
        chk({tag, " out_error0"}, out_error0, 0);
        chk({tag, " err_count0"}, err_count0, 0);
        chk({tag, " out_valid1"}, out_valid1, 0);
        chk({tag, " err_count1"}, err_count1, 0);
    endtask

    task automatic send_bit(input logic b);
        chk("in_ready before bit", in_ready0, 1);
        in_valid = 1'b1;
        in_bit   = b;
        tick();
        in_valid = 1'b0;
        in_bit   = 1'($urandom);
    endtask

    // One complete frame: data bits (with an optional gap), parity bit,
    // verdict checks, optional backpressure, then the output transfer.
    task automatic run_frame(input logic [7:0] data, input logic par,
                             input int gap_at, input int gap_len, input int hold,
                             input logic exp_p0, input logic exp_e0);
        logic exp_p1, exp_e1;
        exp_p1 = ~exp_p0;
        exp_e1 = exp_p1 ^ par;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    in_valid = 1'b0;
                    in_bit   = 1'($urandom);
                    tick();
                    chk("out_valid low in gap", out_valid0, 0);
                end
            end
            send_bit(data[i]);
            chk("out_valid low during data", out_valid0, 0);
        end
        send_bit(par);
        if (exp_e0 && ec0 < 255) ec0++;
        if (exp_e1 && ec1 < 255) ec1++;
        chk("out_valid0", out_valid0, 1);
        chk("out_valid1", out_valid1, 1);
        chk("out_parity0", out_parity0, exp_p0);
        chk("out_error0", out_error0, exp_e0);
        chk("out_parity1", out_parity1, exp_p1);
        chk("out_error1", out_error1, exp_e1);
        chk("err_count0", err_count0, ec0);
        chk("err_count1", err_count1, ec1);
        chk("in_ready0 in hold", in_ready0, 0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom);
            in_bit   = 1'($urandom);
            tick();
            chk("hold in_ready0", in_ready0, 0);
            chk("hold in_ready1", in_ready1, 0);
            chk("hold out_valid0", out_valid0, 1);
            chk("hold out_parity0", out_parity0, exp_p0);
            chk("hold out_error0", out_error0, exp_e0);
            chk("hold out_error1", out_error1, exp_e1);
            chk("hold err_count0", err_count0, ec0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid0 after take", out_valid0, 0);
        chk("out_valid1 after take", out_valid1, 0);
        chk("in_ready0 after take", in_ready0, 1);
    endtask

    vec_t vecs[8];

    initial begin
        logic [7:0] d;
        logic       p, ep;

        vecs[0] = '{8'b0100_1101, 1'b0, -1, 0, 0, 1'b0, 1'b0}; // clean frame
        vecs[1] = '{8'b0100_1101, 1'b1, -1, 0, 0, 1'b0, 1'b1}; // bad frame
        vecs[2] = '{8'b0100_1101, 1'b1, -1, 0, 0, 1'b0, 1'b1}; // second bad
        vecs[3] = '{8'b0100_1101, 1'b0,  4, 2, 3, 1'b0, 1'b0}; // gaps + backpressure
        vecs[4] = '{8'b0000_0111, 1'b0, -1, 0, 0, 1'b1, 1'b1}; // three ones, par 0
        vecs[5] = '{8'b0000_0111, 1'b1,  0, 1, 1, 1'b1, 1'b0}; // three ones, par 1
        vecs[6] = '{8'b0000_0000, 1'b0,  7, 3, 2, 1'b0, 1'b0};
        vecs[7] = '{8'b1111_1111, 1'b1, -1, 0, 0, 1'b0, 1'b1};

        // Reset state, checked while reset is asserted and after release.
        #1;
        chk_reset_outputs("reset");
        tick();
        rst_n = 1'b1;
        tick();
        chk_reset_outputs("post reset");

        for (int v = 0; v < 8; v++) begin
            run_frame(vecs[v].data, vecs[v].par, vecs[v].gap_at, vecs[v].gap_len,
                      vecs[v].hold, vecs[v].exp_p0, vecs[v].exp_e0);
        end

        // Reset mid-frame after five data bits; last verdict had error=1.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid-frame reset");
        ec0 = 0;
        ec1 = 0;
        tick();
        rst_n = 1'b1;
        tick();
        run_frame(8'b0000_0111, 1'b1, -1, 0, 0, 1'b1, 1'b0);

        // Randomized frames against the bit-counting model.
        for (int r = 0; r < 40; r++) begin
            d  = 8'($urandom);
            p  = 1'($urandom);
            ep = 1'($countones(d) % 2);
            run_frame(d, p, int'($urandom_range(0, 9)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 4)), ep, ep ^ p);
        end

        // Saturation: 257 bad frames for the even instance from a clean count.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ec0 = 0;
        ec1 = 0;
        tick();
        for (int f = 1; f <= 257; f++) begin
            d  = 8'($urandom);
            ep = 1'($countones(d) % 2);
            run_frame(d, ~ep, -1, 0, 0, ep, 1'b1);
            if (f == 254) chk("err_count before saturation", err_count0, 254);
            if (f >= 255) chk("err_count saturated", err_count0, 255);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_parity_frame_checker
